// File: rtl/display_scan_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// display_scan_ctrl
//
// Time-multiplexing scanner for a four-digit seven-segment display.
// A shadow copy of four BCD digits, their decimal points and the
// leading-zero enable is held constant for a whole frame. Each digit gets one
// slot of REFRESH_DIV cycles. The first DEAD_CYCLES cycles of a slot keep all
// anodes off, and the rest of the slot lights the digit's anode. Digits with
// invalid codes (>9) are blanked. Leading zeros are blanked when enabled.
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   digits_in   in   [15:12] digit 3 (leftmost) .. [3:0] digit 0 (rightmost)
//   dp_in       in   decimal-point request, bit i <-> digit i
//   lz_en       in   leading-zero suppression enable
//   load        in   strobe: stage digits_in/dp_in/lz_en for the next frame
//   an          out  active-low anode enables, at most one low
//   digit       out  BCD value of the scanned digit for the segment decoder
//   dp          out  decimal point of the scanned digit, active-high
//   digit_sel   out  index of the scanned digit
//   frame_done  out  one-cycle pulse on the first cycle of each new frame
// ---------------------------------------------------------------------------
module display_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        lz_en,
    input  logic        load,
    output logic [3:0]  an,
    output logic [3:0]  digit,
    output logic        dp,
    output logic [1:0]  digit_sel,
    output logic        frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] DEAD_C  = CW'(DEAD_CYCLES);

    typedef enum logic {
        S_DEAD = 1'b0,
        S_ON   = 1'b1
    } state_t;

    // Blanking decision for digit idx of a shadow image.
    function automatic logic is_blank(input logic [15:0] nibs,
                                      input logic        lz,
                                      input logic [1:0]  idx);
        logic [3:0] n;
        logic       upper_zero;
        n          = nibs[4*idx +: 4];
        upper_zero = 1'b1;
        for (int j = 0; j < 4; j++) begin
            if (j >= int'(idx) && nibs[4*j +: 4] != 4'd0) begin
                upper_zero = 1'b0;
            end
        end
        return (n > 4'd9) || (lz && (idx != 2'd0) && upper_zero);
    endfunction

    // Scan state
    logic          run_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sel_q, sel_d;
    state_t        state_q, state_d;
    logic          boundary;

    // Staging and shadow registers
    logic [15:0]   stg_digits_q;
    logic [3:0]    stg_dp_q;
    logic          stg_lz_q;
    logic          pend_q;
    logic [15:0]   sh_digits_q, sh_digits_d;
    logic [3:0]    sh_dp_q, sh_dp_d;
    logic          sh_lz_q, sh_lz_d;

    // Output registers
    logic [3:0]    an_q;
    logic [3:0]    digit_q;
    logic          dp_q;
    logic          frame_done_q;

    always_comb begin
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        boundary = 1'b0;
        // The first edge after reset release only arms the scanner, so the
        // first slot begins cleanly on a full clock cycle.
        if (run_q) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d    = '0;
                sel_d    = sel_q + 2'd1;
                boundary = (sel_q == 2'd3);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // The shadow moves only at the frame boundary. A load on that very
        // cycle bypasses staging so it is seen one cycle later.
        sh_digits_d = sh_digits_q;
        sh_dp_d     = sh_dp_q;
        sh_lz_d     = sh_lz_q;
        if (boundary) begin
            if (load) begin
                sh_digits_d = digits_in;
                sh_dp_d     = dp_in;
                sh_lz_d     = lz_en;
            end else if (pend_q) begin
                sh_digits_d = stg_digits_q;
                sh_dp_d     = stg_dp_q;
                sh_lz_d     = stg_lz_q;
            end
        end

        if (cnt_d == '0) begin
            state_d = S_DEAD;
        end else if (state_q == S_DEAD && cnt_d == DEAD_C) begin
            state_d = S_ON;
        end else begin
            state_d = state_q;
        end
    end

    // Outputs are computed from next state, so they line up with cnt/sel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q        <= 1'b0;
            cnt_q        <= '0;
            sel_q        <= 2'd0;
            state_q      <= S_DEAD;
            stg_digits_q <= 16'h0000;
            stg_dp_q     <= 4'h0;
            stg_lz_q     <= 1'b0;
            pend_q       <= 1'b0;
            sh_digits_q  <= 16'h0000;
            sh_dp_q      <= 4'h0;
            sh_lz_q      <= 1'b0;
            an_q         <= 4'b1111;
            digit_q      <= 4'h0;
            dp_q         <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            run_q   <= 1'b1;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            state_q <= state_d;

            if (load) begin
                stg_digits_q <= digits_in;
                stg_dp_q     <= dp_in;
                stg_lz_q     <= lz_en;
            end
            if (boundary) begin
                pend_q <= 1'b0;
            end else if (load) begin
                pend_q <= 1'b1;
            end

            sh_digits_q <= sh_digits_d;
            sh_dp_q     <= sh_dp_d;
            sh_lz_q     <= sh_lz_d;

            // digit/dp are latched once per slot, on its first DEAD cycle.
            if (cnt_d == '0) begin
                digit_q <= sh_digits_d[4*sel_d +: 4];
                dp_q    <= sh_dp_d[sel_d];
            end

            if (state_d == S_ON && !is_blank(sh_digits_d, sh_lz_d, sel_d)) begin
                an_q <= ~(4'b0001 << sel_d);
            end else begin
                an_q <= 4'b1111;
            end

            frame_done_q <= boundary;
        end
    end

    assign an         = an_q;
    assign digit      = digit_q;
    assign dp         = dp_q;
    assign digit_sel  = sel_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
`timescale 1ns/1ps
module tb_display_scan_ctrl;

    localparam int RDIV = 8;
    localparam int DEAD = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        lz_en;
    logic        load;
    logic [3:0]  an;
    logic [3:0]  digit;
    logic        dp;
    logic [1:0]  digit_sel;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    display_scan_ctrl #(.REFRESH_DIV(RDIV), .DEAD_CYCLES(DEAD)) dut (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in),
        .lz_en(lz_en), .load(load), .an(an), .digit(digit), .dp(dp),
        .digit_sel(digit_sel), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // an_exp holds the ON-phase anode pattern per slot: {s3, s2, s1, s0}
    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  p;
        logic        l;
        logic [15:0] an_exp;
    } vec_t;

    vec_t tab [5];
    vec_t v_rst, v_1111, v_2222, v_8765, prev;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Called on the negedge of the first cycle of a frame; returns on the
    // negedge of the first cycle of the next frame.
    task automatic check_frame(input vec_t v, input bit fd_first);
        for (int c = 0; c < 4 * RDIV; c++) begin
            int s;
            int k;
            logic [3:0] ea;
            s  = c / RDIV;
            k  = c % RDIV;
            ea = (k < DEAD) ? 4'hF : v.an_exp[4*s +: 4];
            chk("an", 16'(an), 16'(ea));
            chk("digit", 16'(digit), 16'(v.d[4*s +: 4]));
            chk("dp", 16'(dp), 16'(v.p[s]));
            chk("digit_sel", 16'(digit_sel), 16'(s));
            chk("frame_done", 16'(frame_done), 16'((c == 0) && fd_first));
            @(negedge clk);
        end
    endtask

    task automatic pulse_load(input vec_t v);
        digits_in = v.d;
        dp_in     = v.p;
        lz_en     = v.l;
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
        digits_in = ~v.d;
        dp_in     = ~v.p;
        lz_en     = ~v.l;
    endtask

    // Wait for the next frame start; the old image must stay on display.
    task automatic wait_fd(input vec_t old);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 5 * RDIV && !found; i++) begin
            if (frame_done) begin
                found = 1'b1;
            end else begin
                chk("hold_digit", 16'(digit), 16'(old.d[4*digit_sel +: 4]));
                @(negedge clk);
            end
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL frame_done_timeout at %0t: got no pulse expected one", $time);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        v_rst   = '{d:16'h0000, p:4'b0000, l:1'b0, an_exp:16'h7BDE};
        tab[0]  = '{d:16'h1234, p:4'b0100, l:1'b0, an_exp:16'h7BDE};
        tab[1]  = '{d:16'h0050, p:4'b0000, l:1'b1, an_exp:16'hFFDE};
        tab[2]  = '{d:16'h0000, p:4'b0000, l:1'b1, an_exp:16'hFFFE};
        tab[3]  = '{d:16'h0900, p:4'b1000, l:1'b1, an_exp:16'hFBDE};
        tab[4]  = '{d:16'h9A09, p:4'b0000, l:1'b0, an_exp:16'h7FDE};
        v_1111  = '{d:16'h1111, p:4'b0000, l:1'b0, an_exp:16'h7BDE};
        v_2222  = '{d:16'h2222, p:4'b0000, l:1'b0, an_exp:16'h7BDE};
        v_8765  = '{d:16'h8765, p:4'b0001, l:1'b0, an_exp:16'h7BDE};

        // Reset state with garbage on the inputs
        rst_n     = 1'b0;
        digits_in = 16'h5678;
        dp_in     = 4'hF;
        lz_en     = 1'b1;
        load      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_an", 16'(an), 16'hF);
        chk("rst_digit", 16'(digit), 16'h0);
        chk("rst_dp", 16'(dp), 16'h0);
        chk("rst_sel", 16'(digit_sel), 16'h0);
        chk("rst_fd", 16'(frame_done), 16'h0);

        // Release: first anode low DEAD+1 edges later, then steady "0000"
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_frame(v_rst, 1'b0);
        check_frame(v_rst, 1'b1);

        // Table: mid-frame load, old image held, new image next frame
        prev = v_rst;
        for (int e = 0; e < 5; e++) begin
            repeat (3) @(negedge clk);
            pulse_load(tab[e]);
            wait_fd(prev);
            check_frame(tab[e], 1'b1);
            prev = tab[e];
        end

        // Two loads in one frame: the last wins
        repeat (2) @(negedge clk);
        pulse_load(v_1111);
        repeat (3) @(negedge clk);
        pulse_load(v_2222);
        wait_fd(prev);
        check_frame(v_2222, 1'b1);

        // Load on the boundary cycle: shown in the very next slot 0
        repeat (4 * RDIV - 1) @(negedge clk);
        chk("bnd_sel", 16'(digit_sel), 16'd3);
        chk("bnd_fd", 16'(frame_done), 16'd0);
        digits_in = v_8765.d;
        dp_in     = v_8765.p;
        lz_en     = v_8765.l;
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
        digits_in = 16'h0000;
        check_frame(v_8765, 1'b1);
        check_frame(v_8765, 1'b1);

        // Asynchronous reset during ON of slot 2
        repeat (2 * RDIV + 4) @(negedge clk);
        chk("pre_rst_an", 16'(an), 16'hB);
        chk("pre_rst_digit", 16'(digit), 16'h7);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_an", 16'(an), 16'hF);
        chk("mid_rst_sel", 16'(digit_sel), 16'h0);
        chk("mid_rst_digit", 16'(digit), 16'h0);
        chk("mid_rst_dp", 16'(dp), 16'h0);
        chk("mid_rst_fd", 16'(frame_done), 16'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_frame(v_rst, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
